// File: rtl/cp0_exc_sequencer.sv
// Purpose : multi-cycle exception-entry / ERET sequencer between control unit and CP0.
// Latency : entry 4 cycles to redirect, ERET 3 cycles, masked request 1 cycle.
// Backpr. : requests are sampled only in IDLE; busy stays high until the done strobe.
//
// Ports:
//   clk, rst             posedge clock, asynchronous active-high reset
//   exc_req/exc_code     exception request and ExcCode (8 syscall, 9 break, 13 teq)
//   epc_in               PC of the excepting instruction
//   eret_req             ERET request (exc_req wins if both are high)
//   cp0_rdata            combinational read data for cp0_raddr
//   cp0_raddr/cp0_ren    CP0 read port
//   cp0_waddr/wdata/wen  CP0 write port (CP0 commits on the following negedge)
//   busy                 high whenever not IDLE
//   redirect_valid/_pc   one-cycle PC redirect strobe and target
//   exc_ignored          one-cycle strobe: exception was masked by Status
//   done                 one-cycle strobe closing every sequence

module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0040_0004,
  parameter int unsigned SHIFT       = 5,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] epc_in,
  input  logic        eret_req,
  input  logic [31:0] cp0_rdata,
  output logic [4:0]  cp0_raddr,
  output logic        cp0_ren,
  output logic [4:0]  cp0_waddr,
  output logic [31:0] cp0_wdata,
  output logic        cp0_wen,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        exc_ignored,
  output logic        done
);

  localparam logic [4:0] CODE_SYSCALL = 5'd8;
  localparam logic [4:0] CODE_BREAK   = 5'd9;
  localparam logic [4:0] CODE_TEQ     = 5'd13;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_STAT  = 3'd1,
    S_CAUSE = 3'd2,
    S_EPC   = 3'd3,
    S_RSTAT = 3'd4,
    S_RDEPC = 3'd5,
    S_JUMP  = 3'd6,
    S_IGN   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_status;
  logic [4:0]  r_code;
  logic [31:0] r_epc;
  logic        r_is_eret;

  logic        w_code_en;
  logic        w_accept;

  // Per-code enable bit in Status; codes without a dedicated bit only need
  // the global enable (bit 0).
  always_comb begin
    w_code_en = 1'b1;
    case (exc_code)
      CODE_SYSCALL: w_code_en = cp0_rdata[1];
      CODE_BREAK:   w_code_en = cp0_rdata[2];
      CODE_TEQ:     w_code_en = cp0_rdata[3];
      default:      w_code_en = 1'b1;
    endcase
  end

  // cp0_rdata is the Status word here because IDLE always reads Status.
  assign w_accept = cp0_rdata[0] & w_code_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Everything written back to CP0 comes from these registers, never from
  // cp0_rdata in the same cycle, so the negedge write cannot race a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status  <= '0;
      r_code    <= '0;
      r_epc     <= '0;
      r_is_eret <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (exc_req) begin
            r_status  <= cp0_rdata;
            r_code    <= exc_code;
            r_epc     <= epc_in;
            r_is_eret <= 1'b0;
          end else if (eret_req) begin
            r_status  <= cp0_rdata;
            r_is_eret <= 1'b1;
          end
        end
        S_RDEPC: begin
          r_epc <= cp0_rdata;
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and Moore outputs. Only the IDLE transition looks at inputs;
  // outputs decode purely from state and captured registers.
  always_comb begin
    w_state_nxt    = r_state;
    cp0_raddr      = ADDR_STATUS;
    cp0_ren        = 1'b0;
    cp0_waddr      = ADDR_STATUS;
    cp0_wdata      = '0;
    cp0_wen        = 1'b0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exc_ignored    = 1'b0;
    done           = 1'b0;

    case (r_state)
      IDLE: begin
        busy    = 1'b0;
        cp0_ren = 1'b1;
        if (exc_req) begin
          w_state_nxt = w_accept ? S_STAT : S_IGN;
        end else if (eret_req) begin
          w_state_nxt = S_RSTAT;
        end
      end

      S_STAT: begin
        cp0_wen     = 1'b1;
        cp0_waddr   = ADDR_STATUS;
        cp0_wdata   = r_status << SHIFT;
        w_state_nxt = S_CAUSE;
      end

      S_CAUSE: begin
        cp0_wen     = 1'b1;
        cp0_waddr   = ADDR_CAUSE;
        cp0_wdata   = {25'b0, r_code, 2'b00};
        w_state_nxt = S_EPC;
      end

      S_EPC: begin
        cp0_wen     = 1'b1;
        cp0_waddr   = ADDR_EPC;
        cp0_wdata   = r_epc;
        w_state_nxt = S_JUMP;
      end

      S_RSTAT: begin
        cp0_wen     = 1'b1;
        cp0_waddr   = ADDR_STATUS;
        cp0_wdata   = r_status >> SHIFT;
        w_state_nxt = S_RDEPC;
      end

      S_RDEPC: begin
        cp0_ren     = 1'b1;
        cp0_raddr   = ADDR_EPC;
        w_state_nxt = S_JUMP;
      end

      S_JUMP: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_is_eret ? r_epc : EXC_VECTOR;
        done           = 1'b1;
        w_state_nxt    = IDLE;
      end

      S_IGN: begin
        exc_ignored = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
